// File: rtl/sap1_pkg.sv
// sap1_pkg: shared widths and program-loader state encoding
// for the SAP-1 RAM loader slice.
package sap1_pkg;

  localparam int LD_ADDR_W = 4;
  localparam int LD_DATA_W = 8;
  localparam int RAM_DEPTH = 2 ** LD_ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ACCEPT   = 4'd1,
    S_SET_ADDR = 4'd2,
    S_WRITE    = 4'd3,
    S_FINISH   = 4'd4,
    S_V_ADDR   = 4'd5,
    S_V_READ   = 4'd6,
    S_V_ACC    = 4'd7,
    S_ERR      = 4'd8
  } ld_state_e;

endpackage

// File: rtl/sap1_addr_counter.sv
// sap1_addr_counter: word counter with clear, increment and
// terminal compare, reused by the load and readback passes.
module sap1_addr_counter
  import sap1_pkg::*;
#(
  parameter int W = LD_ADDR_W + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] n_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q + ONE) == n_i;

endmodule

// File: rtl/sap1_ram_loader.sv
// sap1_ram_loader: program-mode MAR/RAM write sequencer for SAP-1.
// Optional XOR readback check: define SAP1_LOAD_VERIFY_EN.
module sap1_ram_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W = LD_ADDR_W,
  parameter int DATA_W = LD_DATA_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mar_ld,
  output logic [ADDR_W-1:0] addr,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

`ifdef SAP1_LOAD_VERIFY_EN
  localparam ld_state_e AFTER_WR = S_V_ADDR;
`else
  localparam ld_state_e AFTER_WR = S_FINISH;
`endif

  ld_state_e         state_q;
  ld_state_e         state_d;
  logic [CW-1:0]     n_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     len_cap;
  logic [CW-1:0]     cnt;
  logic              cnt_last;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              load_go;
  logic              unused_ok;

  // Requests beyond the RAM depth are clamped so the address never wraps.
  assign len_cap = (len > DEPTH) ? DEPTH : len;

`ifdef SAP1_LOAD_VERIFY_EN
  assign load_go = start &&
                   (state_q == S_IDLE || state_q == S_ERR);
`else
  assign load_go = start && (state_q == S_IDLE);
`endif

  // Counter restarts at zero for the readback pass after the last write.
  assign cnt_clr = load_go ||
                   (state_q == S_WRITE && cnt_last);
`ifdef SAP1_LOAD_VERIFY_EN
  assign cnt_inc = (state_q == S_WRITE) ||
                   (state_q == S_V_ACC);
`else
  assign cnt_inc = (state_q == S_WRITE);
`endif

  sap1_addr_counter #(
    .W (CW)
  ) u_cnt (
    .clk_i  (CLK),
    .rst_i  (CLR),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .n_i    (n_q),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

`ifdef SAP1_LOAD_VERIFY_EN
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] rsum_q;
  logic              sum_ok;

  assign sum_ok = (rsum_q ^ ram_rdata) == csum_q;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      csum_q <= '0;
      rsum_q <= '0;
    end else begin
      if (load_go) begin
        csum_q <= '0;
      end else if (state_q == S_WRITE) begin
        csum_q <= csum_q ^ wdata_q;
      end
      if (state_q == S_WRITE) begin
        rsum_q <= '0;
      end else if (state_q == S_V_ACC) begin
        rsum_q <= rsum_q ^ ram_rdata;
      end
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len_cap == '0) ? S_FINISH : S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid) state_d = S_SET_ADDR;
      end
      S_SET_ADDR: state_d = S_WRITE;
      S_WRITE: state_d = cnt_last ? AFTER_WR : S_ACCEPT;
`ifdef SAP1_LOAD_VERIFY_EN
      S_V_ADDR: state_d = S_V_READ;
      S_V_READ: state_d = S_V_ACC;
      S_V_ACC: begin
        if (!cnt_last) begin
          state_d = S_V_ADDR;
        end else begin
          state_d = sum_ok ? S_FINISH : S_ERR;
        end
      end
      S_ERR: begin
        if (start) begin
          state_d = (len_cap == '0) ? S_FINISH : S_ACCEPT;
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mar_ld   = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:     cpu_hold = 1'b0;
      S_ACCEPT:   in_ready = 1'b1;
      S_SET_ADDR: mar_ld   = 1'b1;
      S_WRITE:    ram_we   = 1'b1;
`ifdef SAP1_LOAD_VERIFY_EN
      S_V_ADDR:   mar_ld   = 1'b1;
      S_V_READ:   ram_re   = 1'b1;
      S_V_ACC:    ;
      S_ERR:      err      = 1'b1;
`endif
      S_FINISH: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      n_q     <= '0;
      wdata_q <= '0;
    end else begin
      if (load_go) n_q <= len_cap;
      if (state_q == S_ACCEPT && in_valid) begin
        wdata_q <= in_data;
      end
    end
  end

  assign addr  = cnt[ADDR_W-1:0];
  assign wdata = wdata_q;

  assign unused_ok = ^{ram_rdata, cnt[ADDR_W]};

endmodule

// File: tb/tb_sap1_ram_loader.sv
// tb_sap1_ram_loader: table-driven and randomized loads checked
// against a byte-list RAM image and cycle-count model.
module tb_sap1_ram_loader;
  import sap1_pkg::*;

  localparam int AW    = LD_ADDR_W;
  localparam int DW    = LD_DATA_W;
  localparam int LW    = AW + 1;
  localparam int DEPTH = RAM_DEPTH;
`ifdef SAP1_LOAD_VERIFY_EN
  localparam int VERIFY = 1;
`else
  localparam int VERIFY = 0;
`endif

  typedef struct {
    int len;
    int gap_at;
    int gap_len;
    int exp_n;
    int exp_off;
  } vec_t;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [AW:0]   len_i;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mar_ld;
  logic [AW-1:0] addr;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] rdata_q = '0;
  logic [DW-1:0] wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  logic [DW-1:0] mem [DEPTH] = '{default: 8'h00};
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] mar_m = '0;
  logic          corrupt_en;
  logic          corrupt_done = 1'b0;

  logic [DW-1:0] stim [32];
  int            gaps [33];
  vec_t          tbl [6];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  sap1_ram_loader dut (
    .CLK       (clk),
    .CLR       (clr),
    .start     (start),
    .len       (len_i),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mar_ld    (mar_ld),
    .addr      (addr),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (rdata_q),
    .wdata     (wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(posedge clk) begin
    if (mar_ld) mar_m <= addr;
    if (ram_we) mem[mar_m] <= wdata;
    if (ram_re) rdata_q <= mem[mar_m];
    if (corrupt_en && !corrupt_done) begin
      mem[1] <= mem[1] ^ 8'hFF;
      corrupt_done <= 1'b1;
    end
  end

  function automatic logic [19:0] outs();
    return {in_ready, mar_ld, addr, ram_we, ram_re,
            wdata, cpu_hold, busy, done, err};
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // mode 0: normal load, 1: corrupt RAM before readback, 2: CLR in write 2
  task automatic run_load(input int ln, input int exp_n,
                          input int exp_off, input int mode,
                          input string nm);
    int k, wc, cyc, done_at, nwe, nml, nre;
    int badaddr, badhold, bad;
    bit fin;
    k = 0; wc = gaps[0]; cyc = 0; done_at = -1;
    nwe = 0; nml = 0; nre = 0; badaddr = 0; badhold = 0;
    fin = 1'b0;
    @(negedge clk);
    start = 1'b1; len_i = LW'(ln); in_valid = 1'b0;
    @(negedge clk);
    while (!fin && cyc < exp_off + 30) begin
      len_i = LW'($urandom_range(0, 31));
      if (done) begin
        fin = 1'b1;
        done_at = cyc;
      end
      if (ram_we) begin
        nwe++;
        if (int'(mar_m) != nwe - 1) badaddr++;
      end
      if (mar_ld) nml++;
      if (ram_re) nre++;
      if (cpu_hold == done) badhold++;
      if (mode == 1 && ram_we && nwe == exp_n) corrupt_en = 1'b1;
      if (mode == 2 && ram_we && nwe == 2) begin
        clr = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk({nm, "_abort_idle"}, int'(outs()), 0);
        for (int i = 0; i < 2; i++) ref_mem[i] = stim[i];
        return;
      end
      start = (mode == 0 && !fin) ?
              1'($urandom_range(0, 1)) : 1'b0;
      in_valid = 1'b0;
      in_data = DW'($urandom);
      if (in_ready && k < exp_n) begin
        if (wc > 0) begin
          wc--;
        end else begin
          in_valid = 1'b1;
          in_data = stim[k];
          k++;
          wc = gaps[k];
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk({nm, "_writes"}, nwe, exp_n);
    chk({nm, "_mar_loads"}, nml, exp_n * (1 + VERIFY));
    chk({nm, "_reads"}, nre, exp_n * VERIFY);
    chk({nm, "_wr_addr"}, badaddr, 0);
    chk({nm, "_hold"}, badhold, 0);
    if (mode == 1) begin
      chk({nm, "_no_done"}, done_at, -1);
      chk({nm, "_err_hold"}, int'({err, cpu_hold, busy}), 7);
    end else begin
      chk({nm, "_done_cycle"}, done_at, exp_off);
      for (int i = 0; i < exp_n; i++) ref_mem[i] = stim[i];
      bad = 0;
      for (int i = 0; i < DEPTH; i++)
        if (mem[i] !== ref_mem[i]) bad++;
      chk({nm, "_ram_image"}, bad, 0);
      chk({nm, "_err"}, int'(err), 0);
      @(negedge clk);
      chk({nm, "_idle_after"}, int'({done, busy, cpu_hold}), 0);
    end
  endtask

  task automatic fill_stim(input bit fixed);
    for (int i = 0; i < 32; i++) stim[i] = DW'($urandom);
    if (fixed) begin
      stim[0] = 8'h09; stim[1] = 8'h1A;
      stim[2] = 8'hE0; stim[3] = 8'hF0;
    end
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < 33; i++) gaps[i] = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, off, ln;
    clr = 1'b1; start = 1'b0; len_i = '0;
    in_valid = 1'b0; in_data = '0; corrupt_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    clear_gaps();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'(outs()), 0);
    clr = 1'b0;

    tbl[0] = '{len: 4,  gap_at: -1, gap_len: 0, exp_n: 4,  exp_off: 12};
    tbl[1] = '{len: 4,  gap_at: 2,  gap_len: 5, exp_n: 4,  exp_off: 17};
    tbl[2] = '{len: 0,  gap_at: -1, gap_len: 0, exp_n: 0,  exp_off: 0};
    tbl[3] = '{len: 20, gap_at: -1, gap_len: 0, exp_n: 16, exp_off: 48};
    tbl[4] = '{len: 16, gap_at: 7,  gap_len: 2, exp_n: 16, exp_off: 50};
    tbl[5] = '{len: 1,  gap_at: 0,  gap_len: 3, exp_n: 1,  exp_off: 6};

    for (int t = 0; t < 6; t++) begin
      clear_gaps();
      if (tbl[t].gap_at >= 0) gaps[tbl[t].gap_at] = tbl[t].gap_len;
      fill_stim(1'b1);
      run_load(tbl[t].len, tbl[t].exp_n,
               tbl[t].exp_off + 3 * VERIFY * tbl[t].exp_n,
               0, $sformatf("vec%0d", t));
    end

    for (int r = 0; r < 8; r++) begin
      ln = $urandom_range(0, 20);
      n = (ln > DEPTH) ? DEPTH : ln;
      fill_stim(1'b0);
      clear_gaps();
      off = 3 * n * (1 + VERIFY);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) gaps[i] = $urandom_range(1, 4);
        off += gaps[i];
      end
      run_load(ln, n, off, 0, $sformatf("rand%0d", r));
    end

    clear_gaps();
    fill_stim(1'b0);
    run_load(4, 4, 12 * (1 + VERIFY), 2, "abort");
    fill_stim(1'b0);
    run_load(4, 4, 12 * (1 + VERIFY), 0, "reload");

`ifdef SAP1_LOAD_VERIFY_EN
    fill_stim(1'b1);
    run_load(4, 4, 24, 1, "verify_err");
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("verify_err_clr", int'({err, cpu_hold, busy}), 0);
    for (int i = 0; i < 4; i++) ref_mem[i] = stim[i];
    ref_mem[1] = ref_mem[1] ^ 8'hFF;
    fill_stim(1'b0);
    run_load(4, 4, 24, 0, "verify_ok");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
